// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: cache controller FSM with write-through/write-back policy, RAM timeout and saturating hit/miss statistics
module cache_ctrl_fsm #(
  parameter int WAYS       = 4,
  parameter int WIDTH      = 8,
  parameter int WRITE_BACK = 0,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic                            re,
  input  logic                            hit,
  input  logic                            victim_dirty,
  input  logic [$clog2(WAYS)-1:0]         chosen_way,
  input  logic [WIDTH-1:0]                data_in,
  input  logic [WIDTH-1:0]                data_from_RAM,
  input  logic [WAYS-1:0][WIDTH-1:0]      data_from_cache,
  input  logic                            ram_ack,
  output logic                            done,
  output logic                            busy,
  output logic                            err,
  output logic                            cache_we,
  output logic                            set_dirty,
  output logic                            clr_dirty,
  output logic                            RAM_we,
  output logic                            ram_re,
  output logic [WIDTH-1:0]                cache_data_in,
  output logic [WIDTH-1:0]                ram_data_out,
  output logic [WIDTH-1:0]                data_out,
  output logic [CNT_WIDTH-1:0]            hit_count,
  output logic [CNT_WIDTH-1:0]            miss_count
);
  localparam int WW = $clog2(WAYS);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RAMWR, RESP} state_t;
  state_t               state_q, state_d;
  logic                 wr_q, wr_d, err_q, err_d;
  logic [WIDTH-1:0]     data_q, data_d, rdata_q, rdata_d;
  logic [WW-1:0]        way_q, way_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hits_q, hits_d, miss_q, miss_d;
  logic                 expired;
  assign expired    = cnt_q == TW'(TIMEOUT - 1);
  assign busy       = state_q != IDLE;
  assign done       = state_q == RESP;
  assign err        = err_q;
  assign data_out   = (done && !wr_q) ? rdata_q : '0;
  assign hit_count  = hits_q;
  assign miss_count = miss_q;
  // next state, captured request fields, counters and cache/RAM strobes
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    data_d = data_q;
    way_d = way_q;
    rdata_d = rdata_q;
    err_d = err_q;
    hits_d = hits_q;
    miss_d = miss_q;
    cnt_d = '0;
    cache_we = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    RAM_we = 1'b0;
    ram_re = 1'b0;
    cache_data_in = '0;
    ram_data_out = '0;
    case (state_q)
      IDLE: if (we || re) begin
        state_d = LOOKUP;
        wr_d = we;
        data_d = data_in;
        way_d = chosen_way;
        rdata_d = '0;
        err_d = 1'b0;
      end
      LOOKUP: if (hit) begin
        hits_d = hits_q + CNT_WIDTH'(~&hits_q);
        if (!wr_q) begin
          rdata_d = data_from_cache[way_q];
          state_d = RESP;
        end else begin
          cache_we = 1'b1;
          cache_data_in = data_q;
          set_dirty = WRITE_BACK != 0;
          state_d = (WRITE_BACK != 0) ? RESP : RAMWR;
        end
      end else begin
        miss_d = miss_q + CNT_WIDTH'(~&miss_q);
        if (wr_q && WRITE_BACK == 0) state_d = RAMWR;
        else if (WRITE_BACK != 0 && victim_dirty) state_d = EVICT;
        else if (!wr_q) state_d = FILL;
        else begin
          cache_we = 1'b1;
          set_dirty = 1'b1;
          cache_data_in = data_q;
          state_d = RESP;
        end
      end
      EVICT: begin
        RAM_we = 1'b1;
        ram_data_out = data_from_cache[way_q];
        if (ram_ack && wr_q) begin
          cache_we = 1'b1;
          set_dirty = 1'b1;
          cache_data_in = data_q;
          state_d = RESP;
        end else if (ram_ack) state_d = FILL;
        else if (expired) begin
          err_d = 1'b1;
          state_d = RESP;
        end else cnt_d = cnt_q + TW'(1);
      end
      FILL: begin
        ram_re = 1'b1;
        if (ram_ack) begin
          cache_we = 1'b1;
          clr_dirty = 1'b1;
          cache_data_in = data_from_RAM;
          rdata_d = data_from_RAM;
          state_d = RESP;
        end else if (expired) begin
          err_d = 1'b1;
          state_d = RESP;
        end else cnt_d = cnt_q + TW'(1);
      end
      RAMWR: begin
        RAM_we = 1'b1;
        ram_data_out = data_q;
        if (ram_ack) state_d = RESP;
        else if (expired) begin
          err_d = 1'b1;
          state_d = RESP;
        end else cnt_d = cnt_q + TW'(1);
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and captured registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      data_q <= '0;
      way_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      hits_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      data_q <= data_d;
      way_q <= way_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      hits_q <= hits_d;
      miss_q <= miss_d;
    end
  end
endmodule
